// File: rtl/pack_sched_pkg.sv
// rtl/pack_sched_pkg.sv - shared types, byte codes and packet layout for pack_scheduler
// Macro PACK_SCHED_CHECKSUM_EN selects whether a trailing checksum byte is part of the packet.
package pack_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_WAIT_CH,
    ST_LOAD,
    ST_STATUS
  } state_e;

  localparam logic [7:0] HEADER      = 8'hA5;
  localparam logic [7:0] ACK         = 8'h06;
  localparam logic [7:0] NAK_CSUM    = 8'h15;
  localparam logic [7:0] NAK_CH      = 8'h16;
  localparam logic [7:0] NAK_TIMEOUT = 8'h17;

  // Byte offsets inside a packet; the header sits at offset 0.
  localparam int OFF_CH   = 1;
  localparam int OFF_CTRL = 2;
  localparam int OFF_LO   = 3;
  localparam int OFF_HI   = 4;
  localparam int OFF_PAT  = 5;

  function automatic int pack_bytes(input int data_bit);
`ifdef PACK_SCHED_CHECKSUM_EN
    return 2 * (data_bit / 8) + 6;
`else
    return 2 * (data_bit / 8) + 5;
`endif
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// rtl/rx_gap_timer.sv - saturating inter-byte gap timer with timeout flag
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr_i       forces the count to zero (takes priority over en_i)
//   en_i        counts one per cycle until LIMIT, then holds
//   timeout_o   high in the cycle whose edge brings the count to LIMIT
module rx_gap_timer #(
  parameter int LIMIT = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flagging on the next count lets the registered status leave LIMIT+1
  // cycles after the clearing byte rather than LIMIT+2.
  assign timeout_o = en_i && !clr_i && (cnt_d == LIM);

endmodule

// File: rtl/pack_scheduler.sv
// rtl/pack_scheduler.sv - UART command-packet scheduler for the serial output channels
// Frames UART bytes into packets, validates them, waits for the target channel
// to go idle, strobes its registers and returns a status byte per packet.
// Macro PACK_SCHED_CHECKSUM_EN: trailing XOR checksum byte present and checked.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_data, i_rx_done_tick        received byte and its one-cycle strobe
//   i_ch_busy                     per-channel busy flags
//   o_ch_sel, o_load              target channel and one-cycle load strobe
//   o_ctrl, o_lo_period, o_hi_period, o_pattern, o_freq_pattern  channel values
//   o_tx_start, o_tx_data         status byte strobe and value
//   o_drop_tick                   byte discarded while a packet is in flight
module pack_scheduler
  import pack_sched_pkg::*;
#(
  parameter int DATA_BIT    = 32,
  parameter int CH_NUM      = 16,
  parameter int TIMEOUT_CLK = 100_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 i_data,
  input  logic                       i_rx_done_tick,
  input  logic [CH_NUM-1:0]          i_ch_busy,
  output logic [$clog2(CH_NUM)-1:0]  o_ch_sel,
  output logic                       o_load,
  output logic [7:0]                 o_ctrl,
  output logic [7:0]                 o_lo_period,
  output logic [7:0]                 o_hi_period,
  output logic [DATA_BIT-1:0]        o_pattern,
  output logic [DATA_BIT-1:0]        o_freq_pattern,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  output logic                       o_drop_tick
);

  localparam int NB        = DATA_BIT / 8;
  localparam int PB        = pack_bytes(DATA_BIT);
  localparam int OFF_FREQ  = OFF_PAT + NB;
  localparam int LAST_DATA = OFF_FREQ + NB - 1;
  localparam int CNT_W     = $clog2(PB + 1);
  localparam int CH_W      = $clog2(CH_NUM);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               store_en;
  logic [7:0]         pkt_q [1:LAST_DATA];
  logic               tmr_clr, tmr_en, tmr_timeout;
  logic [7:0]         tx_data_d;
  logic               drop_d;
  logic [DATA_BIT-1:0] pat_w, frq_w;
`ifdef PACK_SCHED_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic                load_q, tx_start_q, drop_q;
  logic [7:0]          tx_data_q, ctrl_q, lo_q, hi_q;
  logic [CH_W-1:0]     ch_sel_q;
  logic [DATA_BIT-1:0] pat_q, frq_q;

  logic [7:0]      ch_byte;
  logic            ch_ok;
  logic [CH_W-1:0] ch_idx;

  assign ch_byte = pkt_q[OFF_CH];
  assign ch_ok   = ({1'b0, ch_byte} < 9'(CH_NUM));
  assign ch_idx  = ch_byte[CH_W-1:0];

  // Gap timer only runs while a packet is open; any other state keeps it at zero.
  assign tmr_en  = (state_q == ST_RECV);
  assign tmr_clr = (state_q != ST_RECV) || i_rx_done_tick;

  rx_gap_timer #(
    .LIMIT(TIMEOUT_CLK)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .timeout_o(tmr_timeout)
  );

  always_comb begin
    pat_w = '0;
    frq_w = '0;
    for (int i = 0; i < NB; i++) begin
      pat_w[8*i +: 8] = pkt_q[OFF_PAT + i];
      frq_w[8*i +: 8] = pkt_q[OFF_FREQ + i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    store_en  = 1'b0;
    tx_data_d = tx_data_q;
    drop_d    = 1'b0;
`ifdef PACK_SCHED_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_done_tick && (i_data == HEADER)) begin
          state_d = ST_RECV;
          cnt_d   = CNT_W'(1);
`ifdef PACK_SCHED_CHECKSUM_EN
          csum_d  = HEADER;
`endif
        end
      end
      ST_RECV: begin
        // A byte arriving in the timeout cycle still counts.
        if (i_rx_done_tick) begin
          store_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
`ifdef PACK_SCHED_CHECKSUM_EN
          // Folding the checksum byte in too leaves zero on a good packet.
          csum_d   = csum_q ^ i_data;
`endif
          if (cnt_q == CNT_W'(PB - 1)) begin
            state_d = ST_CHECK;
          end
        end else if (tmr_timeout) begin
          tx_data_d = NAK_TIMEOUT;
          state_d   = ST_STATUS;
        end
      end
      ST_CHECK: begin
        drop_d = i_rx_done_tick;
`ifdef PACK_SCHED_CHECKSUM_EN
        if (csum_q != 8'h00) begin
          tx_data_d = NAK_CSUM;
          state_d   = ST_STATUS;
        end else if (!ch_ok) begin
          tx_data_d = NAK_CH;
          state_d   = ST_STATUS;
        end else begin
          state_d   = ST_WAIT_CH;
        end
`else
        if (!ch_ok) begin
          tx_data_d = NAK_CH;
          state_d   = ST_STATUS;
        end else begin
          state_d   = ST_WAIT_CH;
        end
`endif
      end
      ST_WAIT_CH: begin
        drop_d = i_rx_done_tick;
        if (!i_ch_busy[ch_idx]) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        drop_d    = i_rx_done_tick;
        tx_data_d = ACK;
        state_d   = ST_STATUS;
      end
      ST_STATUS: begin
        drop_d  = i_rx_done_tick;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef PACK_SCHED_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PACK_SCHED_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= LAST_DATA; i++) pkt_q[i] <= '0;
    end else if (store_en) begin
      // The checksum byte has no slot; it only feeds the running XOR.
      for (int i = 1; i <= LAST_DATA; i++) begin
        if (cnt_q == CNT_W'(i)) pkt_q[i] <= i_data;
      end
    end
  end

  // Outputs are registered from the next state so each strobe lines up with
  // the cycle the FSM spends in LOAD or STATUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      drop_q     <= 1'b0;
      ch_sel_q   <= '0;
      ctrl_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      pat_q      <= '0;
      frq_q      <= '0;
    end else begin
      load_q     <= (state_d == ST_LOAD);
      tx_start_q <= (state_d == ST_STATUS);
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
      if (state_d == ST_LOAD) begin
        ch_sel_q <= ch_idx;
        ctrl_q   <= pkt_q[OFF_CTRL];
        lo_q     <= pkt_q[OFF_LO];
        hi_q     <= pkt_q[OFF_HI];
        pat_q    <= pat_w;
        frq_q    <= frq_w;
      end
    end
  end

  assign o_load         = load_q;
  assign o_tx_start     = tx_start_q;
  assign o_tx_data      = tx_data_q;
  assign o_drop_tick    = drop_q;
  assign o_ch_sel       = ch_sel_q;
  assign o_ctrl         = ctrl_q;
  assign o_lo_period    = lo_q;
  assign o_hi_period    = hi_q;
  assign o_pattern      = pat_q;
  assign o_freq_pattern = frq_q;

endmodule
